// File: rtl/serial_cmp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : serial_cmp_ctrl
// Purpose  : MSB-first bit-serial magnitude comparator controller. Captures
//            two unsigned operands on an accepted start, presents one bit
//            pair per cycle to the comparator datapath, latches the first
//            differing bit pair and reports gt/eq/lt with a one-cycle done.
// Ports    : clk      - rising-edge clock
//            reset    - asynchronous active-low reset
//            start    - compare request (sampled only in IDLE)
//            a, b     - unsigned operands [WIDTH-1:0]
//            busy     - high in SHIFT and DONE
//            done     - one-cycle result-valid pulse
//            a_bit    - current serial bit of A (0 when shift_en=0)
//            b_bit    - current serial bit of B (0 when shift_en=0)
//            shift_en - high in each cycle a bit pair is presented
//            gt/eq/lt - result flags, held from one done to the next
// Params   : WIDTH    - operand width, 2..32
// Macros   : SERIAL_CMP_EARLY_EXIT_EN - leave SHIFT as soon as a difference
//            is latched instead of always shifting WIDTH bits
// Revision : 1.0 - initial release
// ============================================================================
module serial_cmp_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             a_bit,
  output logic             b_bit,
  output logic             shift_en,
  output logic             gt,
  output logic             eq,
  output logic             lt
);

  localparam int c_CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CW-1:0] c_CNT_INIT = c_CW'(WIDTH - 1);
  localparam logic [c_CW-1:0] c_CNT_ONE  = c_CW'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [c_CW-1:0]  r_cnt;
  logic             r_dgt;
  logic             r_dlt;
  logic             r_gt;
  logic             r_eq;
  logic             r_lt;

  logic w_abit;
  logic w_bbit;
  logic w_new_diff;
  logic w_dgt;
  logic w_dlt;
  logic w_last;
  logic w_exit;

  assign w_abit = r_sa[WIDTH-1];
  assign w_bbit = r_sb[WIDTH-1];

  // Only the first differing pair counts; once either decision bit is set
  // later pairs are ignored.
  assign w_new_diff = (r_state == S_SHIFT) && !(r_dgt || r_dlt) && (w_abit != w_bbit);
  assign w_dgt      = r_dgt | (w_new_diff & w_abit);
  assign w_dlt      = r_dlt | (w_new_diff & w_bbit);
  assign w_last     = (r_cnt == '0);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  assign w_exit = w_last | w_new_diff;
`else
  assign w_exit = w_last;
`endif

  assign gt = r_gt;
  assign eq = r_eq;
  assign lt = r_lt;

  // Next-state and Moore outputs
  always_comb begin
    w_next   = r_state;
    busy     = 1'b0;
    done     = 1'b0;
    shift_en = 1'b0;
    a_bit    = 1'b0;
    b_bit    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_SHIFT;
      end
      S_SHIFT: begin
        busy     = 1'b1;
        shift_en = 1'b1;
        a_bit    = w_abit;
        b_bit    = w_bbit;
        if (w_exit) w_next = S_DONE;
      end
      S_DONE: begin
        busy   = 1'b1;
        done   = 1'b1;
        w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_cnt   <= '0;
      r_dgt   <= 1'b0;
      r_dlt   <= 1'b0;
      r_gt    <= 1'b0;
      r_eq    <= 1'b1;
      r_lt    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa  <= a;
            r_sb  <= b;
            r_cnt <= c_CNT_INIT;
            r_dgt <= 1'b0;
            r_dlt <= 1'b0;
          end
        end
        S_SHIFT: begin
          r_sa  <= {r_sa[WIDTH-2:0], 1'b0};
          r_sb  <= {r_sb[WIDTH-2:0], 1'b0};
          r_cnt <= r_cnt - c_CNT_ONE;
          r_dgt <= w_dgt;
          r_dlt <= w_dlt;
          // Flags take the final decision (including this cycle's pair) on
          // the edge into DONE, so they are valid together with done and
          // stay untouched for the whole SHIFT phase.
          if (w_exit) begin
            r_gt <= w_dgt;
            r_lt <= w_dlt;
            r_eq <= ~(w_dgt | w_dlt);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
